// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
package fwd_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } stage_tag_t;

  // x0 never matches: it is hard-wired to zero and never needs forwarding.
  function automatic logic src_match(input logic [REG_AW_DEF-1:0] rs,
                                     input logic                  use_rs,
                                     input logic [REG_AW_DEF-1:0] rd);
    return use_rs && (rs != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: nearest producing stage wins.
module fwd_sel
  import fwd_pkg::*;
(
  input  logic [REG_AW_DEF-1:0] rs_i,
  input  logic                  use_i,
  input  stage_tag_t            ex_i,
  input  stage_tag_t            mem_i,
  input  stage_tag_t            wb_i,
  output logic [1:0]            sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (ex_i.regwrite && src_match(rs_i, use_i, ex_i.rd)) begin
      sel_o = FWD_EX;
    end else if (mem_i.regwrite && src_match(rs_i, use_i, mem_i.rd)) begin
      sel_o = FWD_MEM;
    end else if (wb_i.regwrite && src_match(rs_i, use_i, wb_i.rd)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: EX/MEM/WB tag pipeline, load-use and
// CGRA scoreboard stalls, and a stall performance counter.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_is_load_i,
  input  logic              id_is_cgra_i,
  input  logic              cgra_done_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              cgra_busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_tag_t ex_q, mem_q, wb_q, ex_d;
  logic              cgra_busy_q, cgra_busy_d;
  logic [REG_AW-1:0] cgra_rd_q, cgra_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              load_use, cgra_hazard, issue;

  fwd_sel u_sel_a (
    .rs_i (id_rs1_i), .use_i (id_use_rs1_i),
    .ex_i (ex_q), .mem_i (mem_q), .wb_i (wb_q), .sel_o (fwd_a_o)
  );

  fwd_sel u_sel_b (
    .rs_i (id_rs2_i), .use_i (id_use_rs2_i),
    .ex_i (ex_q), .mem_i (mem_q), .wb_i (wb_q), .sel_o (fwd_b_o)
  );

  always_comb begin
    load_use = ex_q.is_load && ex_q.regwrite &&
               (src_match(id_rs1_i, id_use_rs1_i, ex_q.rd) ||
                src_match(id_rs2_i, id_use_rs2_i, ex_q.rd));
    // Only one CGRA op may be outstanding, so a second issue waits too.
    cgra_hazard = cgra_busy_q &&
                  (src_match(id_rs1_i, id_use_rs1_i, cgra_rd_q) ||
                   src_match(id_rs2_i, id_use_rs2_i, cgra_rd_q) ||
                   id_is_cgra_i);
    stall_o = id_valid_i && !flush_i && (load_use || cgra_hazard);
    issue   = id_valid_i && !stall_o && !flush_i;
  end

  always_comb begin
    ex_d        = '0;
    cgra_busy_d = cgra_busy_q;
    cgra_rd_d   = cgra_rd_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_o);
    if (issue) begin
      // A CGRA result bypasses the pipeline tags; the scoreboard tracks it.
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_regwrite_i && !id_is_cgra_i;
      ex_d.is_load  = id_is_load_i && !id_is_cgra_i;
    end
    if (issue && id_is_cgra_i) begin
      cgra_busy_d = 1'b1;
      cgra_rd_d   = id_rd_i;
    end else if (cgra_done_i && cgra_busy_q) begin
      cgra_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      cgra_busy_q <= 1'b0;
      cgra_rd_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      cgra_busy_q <= cgra_busy_d;
      cgra_rd_q   <= cgra_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cgra_busy_o = cgra_busy_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
